// File: rtl/tlv5618_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tlv5618_pkg
//  Brief   : Shared encodings, word bit positions, FSM state type and the
//            TLV5618 control/data word assembly function.
//  Revision: 1.0 - initial release
// ============================================================================
package tlv5618_pkg;

    // Channel selection encodings carried on the request mode field
    localparam logic [1:0] c_mode_a   = 2'b00;
    localparam logic [1:0] c_mode_b   = 2'b01;
    localparam logic [1:0] c_mode_ab  = 2'b10;
    localparam logic [1:0] c_mode_rsv = 2'b11;

    // R1/R0 register-select codes, packed as {R1, R0}
    localparam logic [1:0] c_rc_buf  = 2'b01;  // write buffer
    localparam logic [1:0] c_rc_daca = 2'b10;  // write DAC A, update DAC B from buffer
    localparam logic [1:0] c_rc_dacb = 2'b00;  // write DAC B, update buffer

    // Control bit positions inside the 16-bit word
    localparam int c_bit_r1  = 15;
    localparam int c_bit_spd = 14;
    localparam int c_bit_pwr = 13;
    localparam int c_bit_r0  = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Places the control bits at their fixed positions above the 12-bit code
    function automatic logic [15:0] build_word(input logic       r1,
                                               input logic       r0,
                                               input logic       spd,
                                               input logic       pwr,
                                               input logic [11:0] data);
        logic [15:0] w;
        w             = {4'b0000, data};
        w[c_bit_r1]  = r1;
        w[c_bit_spd] = spd;
        w[c_bit_pwr] = pwr;
        w[c_bit_r0]  = r0;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlv5618_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : tlv5618_ctrl_if
//  Brief   : Request/status bus plus the serializer handshake of the TLV5618
//            command sequencer. slave = sequencer view, master = driver view.
//  Revision: 1.0 - initial release
// ============================================================================
interface tlv5618_ctrl_if;

    logic        req;
    logic [1:0]  mode;
    logic [11:0] ch_a;
    logic [11:0] ch_b;
    logic        spd;
    logic        pwr;
    logic        busy;
    logic        done;
    logic        err;
    logic        dac_start;
    logic [15:0] dac_word;
    logic        set_done;

    modport slave (
        input  req, mode, ch_a, ch_b, spd, pwr, set_done,
        output busy, done, err, dac_start, dac_word
    );

    modport master (
        output req, mode, ch_a, ch_b, spd, pwr, set_done,
        input  busy, done, err, dac_start, dac_word
    );

endinterface
`default_nettype wire

// File: rtl/tlv5618_word_fmt.sv
`default_nettype none
// ============================================================================
//  Module  : tlv5618_word_fmt
//  Brief   : Combinational assembly of one 16-bit TLV5618 control/data word.
//  Revision: 1.0 - initial release
// ============================================================================
module tlv5618_word_fmt
    import tlv5618_pkg::*;
(
    input  wire logic        i_r1,
    input  wire logic        i_r0,
    input  wire logic        i_spd,
    input  wire logic        i_pwr,
    input  wire logic [11:0] i_data,
    output logic      [15:0] o_word
);

    // Pure bit placement, shared with any other user of the package function
    always_comb begin
        o_word = build_word(i_r1, i_r0, i_spd, i_pwr, i_data);
    end

endmodule
`default_nettype wire

// File: rtl/tlv5618_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tlv5618_ctrl
//  Brief   : TLV5618 command sequencer. Turns a one/two channel update request
//            into serializer frames, buffer-first for dual updates so both
//            outputs change together, with an inter-frame gap and a timeout.
//  Revision: 1.0 - initial release
// ============================================================================
module tlv5618_ctrl
    import tlv5618_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic      clk,
    input  wire logic      rst,
    tlv5618_ctrl_if.slave  bus
);

    // One counter covers both the gap (<=255) and the timeout
    localparam int c_cw = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [c_cw-1:0] c_gap_last = c_cw'(GAP_CYCLES - 1);
    localparam logic [c_cw-1:0] c_to_last  = c_cw'(TIMEOUT - 1);

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [11:0]       r_ch_a;
    logic              r_spd;
    logic              r_pwr;
    logic              r_last;      // word in flight is the final one of the request
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_dac_start;
    logic [15:0]       r_dac_word;

    logic [1:0]        w_rc;
    logic [11:0]       w_data;
    logic              w_spd;
    logic              w_pwr;
    logic [15:0]       w_word;

    // Next word to issue: from the live request in IDLE, from the captured
    // channel A code when the dual update resumes after the gap
    always_comb begin
        w_rc   = c_rc_daca;
        w_data = bus.ch_a;
        w_spd  = bus.spd;
        w_pwr  = bus.pwr;
        if (r_state == ST_GAP) begin
            w_rc   = c_rc_daca;
            w_data = r_ch_a;
            w_spd  = r_spd;
            w_pwr  = r_pwr;
        end else begin
            case (bus.mode)
                c_mode_b:  begin w_rc = c_rc_dacb; w_data = bus.ch_b; end
                c_mode_ab: begin w_rc = c_rc_buf;  w_data = bus.ch_b; end
                default:   begin w_rc = c_rc_daca; w_data = bus.ch_a; end
            endcase
        end
    end

    tlv5618_word_fmt u_word_fmt (
        .i_r1   (w_rc[1]),
        .i_r0   (w_rc[0]),
        .i_spd  (w_spd),
        .i_pwr  (w_pwr),
        .i_data (w_data),
        .o_word (w_word)
    );

    // Sequencer FSM with registered outputs; the counter clears on every state entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ch_a      <= '0;
            r_spd       <= 1'b0;
            r_pwr       <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_dac_start <= 1'b0;
            r_dac_word  <= 16'h0000;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_dac_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.req) begin
                        if (bus.mode == c_mode_rsv) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_busy      <= 1'b1;
                            r_dac_start <= 1'b1;
                            r_dac_word  <= w_word;
                            r_ch_a      <= bus.ch_a;
                            r_spd       <= bus.spd;
                            r_pwr       <= bus.pwr;
                            r_last      <= (bus.mode != c_mode_ab);
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    // set_done takes priority over a coincident timeout
                    if (bus.set_done) begin
                        r_cnt <= '0;
                        if (r_last) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (r_cnt == c_to_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_state     <= ST_ISSUE;
                        r_cnt       <= '0;
                        r_dac_start <= 1'b1;
                        r_dac_word  <= w_word;
                        r_last      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.dac_start = r_dac_start;
    assign bus.dac_word  = r_dac_word;

endmodule
`default_nettype wire
